conv_tap_sequencer: RTL and testbench
=====================================

Name: conv_tap_sequencer

Overview:
Control FSM that drives one ConvParaScaleFloat16 PARA_X x PARA_Y MAC array through a single kernel window. Per cycle it issues a kernel-tap coordinate, a weight address and an operand load mode to the feature/weight buffer front end. It holds the datapath's active-low reset and exposes the finished window through a valid/accept handshake. It sits between the layer-level loop controller and the MAC array.

Parameters:
PARA_X, 3, MAC groups (operands refreshed on horizontal step)
PARA_Y, 3, MACs per group (operands refreshed on vertical step)
KERNEL_SIZE_MAX, 11, largest legal kernel
KERNEL_SIZE_WIDTH, 6, width of kernel_size fields
WADDR_WIDTH, 7, weight address width (must hold KERNEL_SIZE_MAX^2-1)
DRAIN_TIMEOUT, 64, max cycles waiting for dp_result_ready

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  request one window; sampled only in IDLE
kernel_size  in  KERNEL_SIZE_WIDTH  K for the requested window
busy  out  1  high in any state except IDLE
err  out  1  one-cycle pulse: illegal K at start, or drain timeout
dp_rst_n  out  1  to datapath rst; 0 = hold datapath in reset
dp_kernel_size  out  KERNEL_SIZE_WIDTH  latched K, to datapath
tap_valid  out  1  high while a tap is being issued
tap_row  out  KERNEL_SIZE_WIDTH  kernel row r
tap_col  out  KERNEL_SIZE_WIDTH  kernel column c
load_mode  out  3  0 NONE, 1 FULL, 2 NEW_X, 3 NEW_Y, 4 SINGLE
weight_addr  out  WADDR_WIDTH  r*K + c
dp_result_ready  in  1  datapath result_ready
result_valid  out  1  window result available on datapath result_buffer
result_accept  in  1  consumer took the result

Behaviour:
- All outputs are registered. Reset value is 0 on every output, so dp_rst_n=0 and the datapath is held in reset. FSM resets to IDLE.
- States: IDLE, FEED, DRAIN, HOLD.
- IDLE: dp_rst_n=0.
  - start=1 with 1<=kernel_size<=KERNEL_SIZE_MAX: latch K into dp_kernel_size, go to FEED.
  - Next cycle outputs: dp_rst_n=1, tap_valid=1, tap (0,0), load_mode=FULL, weight_addr=0.
  - start=1 with K=0 or K>KERNEL_SIZE_MAX: err pulses next cycle, stay in IDLE.
- FEED: one tap per cycle for exactly K*K cycles, row-major (c increments; at c=K-1, c wraps to 0 and r increments).
  - load_mode per tap: (0,0) FULL; r=0, c>0 NEW_X; r>0, c=0 NEW_Y; otherwise SINGLE.
  - After tap (K-1,K-1), go to DRAIN. tap_valid=0, load_mode=NONE.
  - K=1: a single FULL tap, then DRAIN.
- DRAIN: dp_rst_n=1, counts cycles.
  - dp_result_ready=1: go to HOLD, result_valid=1 next cycle.
  - Counter reaching DRAIN_TIMEOUT first: err pulse, go to IDLE (dp_rst_n=0).
- HOLD: result_valid=1, dp_rst_n=1 until result_accept=1. On accept: result_valid=0 and dp_rst_n=0 next cycle, state IDLE.
- Back-to-back: start may be asserted in the same cycle as result_accept. It is ignored; the earliest new FEED begins 2 cycles after accept, which guarantees at least one dp_rst_n=0 cycle between windows.
- start outside IDLE is ignored (no err).
- kernel_size changes after acceptance have no effect.
- Start-to-first-tap latency: 1 cycle. Start-to-DRAIN: K*K+1 cycles.
- Arithmetic: weight_addr is computed incrementally (+1 per tap, 0 at start), not with a multiplier. Counters are KERNEL_SIZE_WIDTH wide.
- Asserting rst mid-FEED/DRAIN/HOLD immediately forces all outputs to 0 and returns the FSM to IDLE. No err pulse.

Decomposition:
- Shared package conv_ctrl_pkg: load_mode encodings (LM_NONE..LM_SINGLE), FSM state encodings, default PARA_X/PARA_Y/KERNEL_SIZE_MAX/KERNEL_SIZE_WIDTH.
- One natural sub-module: conv_tap_counter (r/c/weight_addr counter with wrap and last-tap flag). The FSM stays in the top.

Test Plan:
- K=3, start 1 cycle: 9 taps. load_mode sequence FULL,NEW_X,NEW_X,NEW_Y,SINGLE,SINGLE,NEW_Y,SINGLE,SINGLE. weight_addr 0..8. dp_rst_n rises with first tap.
- K=5 with datapath model raising dp_result_ready 4 cycles after the last tap: 25 taps, result_valid 1 cycle after ready. Hold result_accept low 3 cycles; result_valid stays 1. Accept, then dp_rst_n=0 next cycle.
- K=0 and K=12 starts: err pulses 1 cycle, busy stays 0, no tap_valid.
- K=1: exactly one FULL tap at (0,0), weight_addr=0, then DRAIN.
- dp_result_ready never asserted, K=3: err pulses after DRAIN_TIMEOUT=64 cycles in DRAIN, then IDLE with dp_rst_n=0.
- rst asserted at tap (1,2) of K=3: all outputs 0 asynchronously. A fresh start after release restarts at (0,0) FULL. start asserted during FEED is ignored.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution tap sequencer.
// Holds the default array/kernel geometry, the operand load-mode encodings
// seen by the feature/weight buffer front end, the sequencer FSM state
// encodings, and the helper that maps a tap position to its load mode.
package conv_ctrl_pkg;

  localparam int PARA_X            = 3;   // MAC groups (refreshed on horizontal step)
  localparam int PARA_Y            = 3;   // MACs per group (refreshed on vertical step)
  localparam int KERNEL_SIZE_MAX   = 11;
  localparam int KERNEL_SIZE_WIDTH = 6;
  localparam int WADDR_WIDTH       = 7;
  localparam int DRAIN_TIMEOUT     = 64;

  typedef enum logic [2:0] {
    LM_NONE   = 3'd0,
    LM_FULL   = 3'd1,
    LM_NEW_X  = 3'd2,
    LM_NEW_Y  = 3'd3,
    LM_SINGLE = 3'd4
  } load_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // The first tap loads every operand. Along row 0 only the new column of
  // features enters; at the start of a later row only the new row enters.
  // Everywhere else only a single operand changes.
  function automatic load_mode_e tap_load_mode(input logic row_zero,
                                               input logic col_zero);
    load_mode_e m;
    if (row_zero && col_zero) m = LM_FULL;
    else if (row_zero)        m = LM_NEW_X;
    else if (col_zero)        m = LM_NEW_Y;
    else                      m = LM_SINGLE;
    return m;
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Row-major kernel tap counter.
// Steps (row, col) through a K x K window, wrapping col at K-1, and keeps the
// weight address as a running +1 count so no multiplier is needed.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               force row/col/addr to 0 on the next edge (wins over advance)
//   advance             move to the next tap on the next edge
//   k                   kernel size K (must be >= 1 while advancing)
//   row, col, addr      registered current tap
//   row_zero_d,
//   col_zero_d          next-cycle row/col are 0 (lets the owner register load mode)
//   last                current tap is (K-1, K-1)
module conv_tap_counter
  import conv_ctrl_pkg::*;
#(
  parameter int KW  = KERNEL_SIZE_WIDTH,
  parameter int WAW = WADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  input  logic [KW-1:0]  k,
  output logic [KW-1:0]  row,
  output logic [KW-1:0]  col,
  output logic [WAW-1:0] addr,
  output logic           row_zero_d,
  output logic           col_zero_d,
  output logic           last
);

  logic [KW-1:0]  row_q, row_d;
  logic [KW-1:0]  col_q, col_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic [KW-1:0]  k_m1;

  assign k_m1 = k - KW'(1);

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      addr_d = addr_q + WAW'(1);
      if (col_q == k_m1) begin
        col_d = '0;
        row_d = row_q + KW'(1);
      end else begin
        col_d = col_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign addr       = addr_q;
  assign row_zero_d = (row_d == '0);
  assign col_zero_d = (col_d == '0);
  assign last       = (row_q == k_m1) && (col_q == k_m1);

endmodule

// File: rtl/conv_tap_sequencer.sv
// Control FSM driving one PARA_X x PARA_Y MAC array through a single kernel
// window: one tap coordinate, weight address and operand load mode per cycle,
// then waits for the datapath result and hands it over with valid/accept.
// Every output is registered and resets to 0, so the datapath sits in reset
// (dp_rst_n=0) whenever the sequencer is idle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, kernel_size       window request (sampled only in IDLE)
//   busy, err                status; err is a one-cycle pulse
//   dp_rst_n, dp_kernel_size datapath reset and latched K
//   tap_valid, tap_row,
//   tap_col, load_mode,
//   weight_addr              per-cycle tap issue to the buffer front end
//   dp_result_ready          datapath finished the window
//   result_valid,
//   result_accept            result handshake with the consumer
module conv_tap_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE_MAX   = conv_ctrl_pkg::KERNEL_SIZE_MAX,
  parameter int KERNEL_SIZE_WIDTH = conv_ctrl_pkg::KERNEL_SIZE_WIDTH,
  parameter int WADDR_WIDTH       = conv_ctrl_pkg::WADDR_WIDTH,
  parameter int DRAIN_TIMEOUT     = conv_ctrl_pkg::DRAIN_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
  output logic                         busy,
  output logic                         err,
  output logic                         dp_rst_n,
  output logic [KERNEL_SIZE_WIDTH-1:0] dp_kernel_size,
  output logic                         tap_valid,
  output logic [KERNEL_SIZE_WIDTH-1:0] tap_row,
  output logic [KERNEL_SIZE_WIDTH-1:0] tap_col,
  output logic [2:0]                   load_mode,
  output logic [WADDR_WIDTH-1:0]       weight_addr,
  input  logic                         dp_result_ready,
  output logic                         result_valid,
  input  logic                         result_accept
);

  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

  state_e                       state_q, state_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;
  logic                         dp_rst_n_q, dp_rst_n_d;
  logic [KERNEL_SIZE_WIDTH-1:0] dp_kernel_size_q, dp_kernel_size_d;
  logic                         tap_valid_q, tap_valid_d;
  load_mode_e                   load_mode_q, load_mode_d;
  logic                         result_valid_q, result_valid_d;
  logic [DCW-1:0]               drain_cnt_q, drain_cnt_d;

  logic tap_advance, tap_clear, tap_last;
  logic tap_row_zero_d, tap_col_zero_d;
  logic k_legal;

  assign k_legal = (kernel_size != '0) &&
                   (kernel_size <= KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX));

  // The counter only moves between taps of a window; in every other case it
  // is cleared, so the start of a window always sees (0,0) and address 0.
  assign tap_advance = (state_q == ST_FEED) && !tap_last;
  assign tap_clear   = !tap_advance;

  conv_tap_counter #(
    .KW  (KERNEL_SIZE_WIDTH),
    .WAW (WADDR_WIDTH)
  ) u_tap_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (tap_clear),
    .advance    (tap_advance),
    .k          (dp_kernel_size_q),
    .row        (tap_row),
    .col        (tap_col),
    .addr       (weight_addr),
    .row_zero_d (tap_row_zero_d),
    .col_zero_d (tap_col_zero_d),
    .last       (tap_last)
  );

  always_comb begin
    state_d          = state_q;
    err_d            = 1'b0;
    dp_rst_n_d       = 1'b0;
    dp_kernel_size_d = dp_kernel_size_q;
    tap_valid_d      = 1'b0;
    load_mode_d      = LM_NONE;
    result_valid_d   = 1'b0;
    drain_cnt_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (k_legal) begin
            state_d          = ST_FEED;
            dp_kernel_size_d = kernel_size;
            dp_rst_n_d       = 1'b1;
            tap_valid_d      = 1'b1;
            load_mode_d      = LM_FULL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_FEED: begin
        dp_rst_n_d = 1'b1;
        if (tap_last) begin
          state_d = ST_DRAIN;
        end else begin
          tap_valid_d = 1'b1;
          load_mode_d = tap_load_mode(tap_row_zero_d, tap_col_zero_d);
        end
      end

      ST_DRAIN: begin
        dp_rst_n_d = 1'b1;
        // A result arriving on the final count still wins over the timeout.
        if (dp_result_ready) begin
          state_d        = ST_HOLD;
          result_valid_d = 1'b1;
        end else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          dp_rst_n_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end

      ST_HOLD: begin
        // start is not looked at here; returning through IDLE guarantees at
        // least one dp_rst_n=0 cycle between windows.
        if (result_accept) begin
          state_d = ST_IDLE;
        end else begin
          dp_rst_n_d     = 1'b1;
          result_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
      dp_rst_n_q       <= 1'b0;
      dp_kernel_size_q <= '0;
      tap_valid_q      <= 1'b0;
      load_mode_q      <= LM_NONE;
      result_valid_q   <= 1'b0;
      drain_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      err_q            <= err_d;
      dp_rst_n_q       <= dp_rst_n_d;
      dp_kernel_size_q <= dp_kernel_size_d;
      tap_valid_q      <= tap_valid_d;
      load_mode_q      <= load_mode_d;
      result_valid_q   <= result_valid_d;
      drain_cnt_q      <= drain_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign err            = err_q;
  assign dp_rst_n       = dp_rst_n_q;
  assign dp_kernel_size = dp_kernel_size_q;
  assign tap_valid      = tap_valid_q;
  assign load_mode      = load_mode_q;
  assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed bench for conv_tap_sequencer: tap ordering and load modes, result
// handshake, illegal kernel sizes, K=1, drain timeout, back-to-back start and
// asynchronous reset mid-window.
module tb_conv_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] kernel_size;
  logic       busy, err, dp_rst_n, tap_valid, result_valid;
  logic [5:0] dp_kernel_size, tap_row, tap_col;
  logic [2:0] load_mode;
  logic [6:0] weight_addr;
  logic       dp_result_ready, result_accept;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Hand-derived load modes for K=3, row-major.
  logic [2:0] lm3 [9] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd4};

  always #5 clk = ~clk;

  conv_tap_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .kernel_size     (kernel_size),
    .busy            (busy),
    .err             (err),
    .dp_rst_n        (dp_rst_n),
    .dp_kernel_size  (dp_kernel_size),
    .tap_valid       (tap_valid),
    .tap_row         (tap_row),
    .tap_col         (tap_col),
    .load_mode       (load_mode),
    .weight_addr     (weight_addr),
    .dp_result_ready (dp_result_ready),
    .result_valid    (result_valid),
    .result_accept   (result_accept)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_dp_rst_n"}, 32'(dp_rst_n),     32'd0);
    check({tag, "_tap_vld"},  32'(tap_valid),    32'd0);
    check({tag, "_res_vld"},  32'(result_valid), 32'd0);
  endtask

  task automatic start_win(input int k);
    start       = 1'b1;
    kernel_size = 6'(k);
    step();
    start       = 1'b0;
  endtask

  function automatic logic [2:0] exp_mode(input int r, input int c);
    if (r == 0 && c == 0) return 3'd1;
    if (r == 0)           return 3'd2;
    if (c == 0)           return 3'd3;
    return 3'd4;
  endfunction

  // Walks a whole window from its first tap; returns in the first DRAIN cycle.
  task automatic run_taps(input int k);
    for (int i = 0; i < k * k; i++) begin
      check($sformatf("k%0d_tap%0d_vld", k, i),  32'(tap_valid),   32'd1);
      check($sformatf("k%0d_tap%0d_row", k, i),  32'(tap_row),     32'(i / k));
      check($sformatf("k%0d_tap%0d_col", k, i),  32'(tap_col),     32'(i % k));
      check($sformatf("k%0d_tap%0d_addr", k, i), 32'(weight_addr), 32'(i));
      check($sformatf("k%0d_tap%0d_mode", k, i), 32'(load_mode),   32'(exp_mode(i / k, i % k)));
      step();
    end
    check($sformatf("k%0d_drain_tap_vld", k), 32'(tap_valid), 32'd0);
    check($sformatf("k%0d_drain_busy", k),    32'(busy),      32'd1);
  endtask

  initial begin
    int bad;
    rst             = 1'b1;
    start           = 1'b0;
    kernel_size     = '0;
    dp_result_ready = 1'b0;
    result_accept   = 1'b0;

    #12;
    check("reset_ctl", {27'd0, busy, err, dp_rst_n, tap_valid, result_valid}, 32'd0);
    check("reset_dat", {3'd0, load_mode, weight_addr, tap_row, tap_col, dp_kernel_size}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle("post_reset");

    // K=3 full window with table-driven load modes.
    start_win(3);
    check("k3_dp_ks", 32'(dp_kernel_size), 32'd3);
    check("k3_busy",  32'(busy),           32'd1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("k3_tap%0d_vld", i),  32'(tap_valid),   32'd1);
      check($sformatf("k3_tap%0d_rstn", i), 32'(dp_rst_n),    32'd1);
      check($sformatf("k3_tap%0d_row", i),  32'(tap_row),     32'(i / 3));
      check($sformatf("k3_tap%0d_col", i),  32'(tap_col),     32'(i % 3));
      check($sformatf("k3_tap%0d_addr", i), 32'(weight_addr), 32'(i));
      check($sformatf("k3_tap%0d_mode", i), 32'(load_mode),   32'(lm3[i]));
      step();
    end
    check("k3_drain_tap_vld", 32'(tap_valid), 32'd0);
    check("k3_drain_mode",    32'(load_mode), 32'd0);
    check("k3_drain_rstn",    32'(dp_rst_n),  32'd1);
    dp_result_ready = 1'b1;
    step();
    dp_result_ready = 1'b0;
    check("k3_res_vld", 32'(result_valid), 32'd1);
    result_accept = 1'b1;
    step();
    result_accept = 1'b0;
    check_idle("k3_after_accept");

    // Illegal kernel sizes.
    for (int j = 0; j < 2; j++) begin
      start       = 1'b1;
      kernel_size = (j == 0) ? 6'd0 : 6'd12;
      step();
      start = 1'b0;
      check($sformatf("bad_k%0d_err", j),     32'(err),            32'd1);
      check($sformatf("bad_k%0d_busy", j),    32'(busy),           32'd0);
      check($sformatf("bad_k%0d_tap_vld", j), 32'(tap_valid),      32'd0);
      check($sformatf("bad_k%0d_dp_ks", j),   32'(dp_kernel_size), 32'd3);
      step();
      check($sformatf("bad_k%0d_err_pulse", j), 32'(err),  32'd0);
      check($sformatf("bad_k%0d_busy2", j),     32'(busy), 32'd0);
    end

    // K=1: single FULL tap.
    start_win(1);
    check("k1_vld",  32'(tap_valid),   32'd1);
    check("k1_rc",   {tap_row, tap_col}, 32'd0);
    check("k1_addr", 32'(weight_addr), 32'd0);
    check("k1_mode", 32'(load_mode),   32'd1);
    step();
    check("k1_drain_vld",  32'(tap_valid), 32'd0);
    check("k1_drain_busy", 32'(busy),      32'd1);
    dp_result_ready = 1'b1;
    step();
    dp_result_ready = 1'b0;
    check("k1_res_vld", 32'(result_valid), 32'd1);
    result_accept = 1'b1;
    step();
    result_accept = 1'b0;
    check_idle("k1_after_accept");

    // K=3 with no result: drain timeout after 64 DRAIN cycles.
    start_win(3);
    run_taps(3);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (err !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check("to_drain_clean", 32'(bad),      32'd0);
    check("to_err",         32'(err),      32'd1);
    check("to_busy",        32'(busy),     32'd0);
    check("to_dp_rst_n",    32'(dp_rst_n), 32'd0);
    step();
    check("to_err_pulse", 32'(err), 32'd0);

    // K=5, result 4 cycles after the last tap, delayed accept.
    start_win(5);
    run_taps(5);
    step();
    step();
    step();
    check("k5_res_early", 32'(result_valid), 32'd0);
    dp_result_ready = 1'b1;
    step();
    dp_result_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("k5_hold%0d_vld", j),  32'(result_valid), 32'd1);
      check($sformatf("k5_hold%0d_rstn", j), 32'(dp_rst_n),     32'd1);
      step();
    end
    // start together with accept is ignored; held high it is taken in IDLE.
    result_accept = 1'b1;
    start         = 1'b1;
    kernel_size   = 6'd3;
    step();
    result_accept = 1'b0;
    check_idle("b2b_gap");
    step();
    start = 1'b0;
    check("b2b_tap_vld", 32'(tap_valid), 32'd1);
    check("b2b_mode",    32'(load_mode), 32'd1);

    // start during FEED is ignored; reset at tap (1,2).
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start       = 1'b1;
        kernel_size = 6'd7;
      end
      step();
      start       = 1'b0;
      kernel_size = 6'd3;
    end
    check("mid_row",   32'(tap_row),        32'd1);
    check("mid_col",   32'(tap_col),        32'd2);
    check("mid_addr",  32'(weight_addr),    32'd5);
    check("mid_mode",  32'(load_mode),      32'd4);
    check("mid_dp_ks", 32'(dp_kernel_size), 32'd3);
    check("mid_err",   32'(err),            32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_ctl", {27'd0, busy, err, dp_rst_n, tap_valid, result_valid}, 32'd0);
    check("arst_dat", {3'd0, load_mode, weight_addr, tap_row, tap_col, dp_kernel_size}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle("post_arst");
    check("post_arst_err", 32'(err), 32'd0);
    start_win(3);
    check("restart_vld",  32'(tap_valid),   32'd1);
    check("restart_rc",   {tap_row, tap_col}, 32'd0);
    check("restart_addr", 32'(weight_addr), 32'd0);
    check("restart_mode", 32'(load_mode),   32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
